// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Provides address/instruction types, reset values, FSM states and cache geometry.
package inst_fetch_unit_pkg;

   localparam int ADDR_TYPE = 32;
   localparam int INST_TYPE = 32;

   typedef logic [ADDR_TYPE-1:0] addr_t;
   typedef logic [INST_TYPE-1:0] inst_t;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam addr_t ADDR_RESET = '0;
   localparam inst_t INST_RESET = '0;

   typedef enum logic [1:0] {
      LOOKUP = 2'd0,
      REQ    = 2'd1,
      REFILL = 2'd2,
      DRAIN  = 2'd3
   } fetch_state_t;

   localparam int DEF_INDEX_BITS    = 4;
   localparam int DEF_WORD_OFF_BITS = 2;

   // Clears the word-offset and byte bits of an address.
   function automatic addr_t line_base(input addr_t a, input int off_bits);
      addr_t m;
      m = '1;
      m = m << (off_bits + 2);
      return a & m;
   endfunction

endpackage

// File: rtl/inst_fetch_unit_icache.sv
// Direct-mapped instruction cache storage: tags, line valid bits and data words.
// Ports: rd_addr -> hit/rd_word (combinational); wr_en/wr_off/wr_word, set_valid, clr_valid on line_addr.
module icache_array
   import inst_fetch_unit_pkg::*;
#(
   parameter int INDEX_BITS    = DEF_INDEX_BITS,
   parameter int WORD_OFF_BITS = DEF_WORD_OFF_BITS
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                en,
   input  logic [ADDR_TYPE-1:2]                rd_addr,
   output logic                                hit,
   output inst_t                               rd_word,
   input  logic                                wr_en,
   input  logic [ADDR_TYPE-1:WORD_OFF_BITS+2]  line_addr,
   input  logic [WORD_OFF_BITS-1:0]            wr_off,
   input  inst_t                               wr_word,
   input  logic                                set_valid,
   input  logic                                clr_valid
);

   localparam int IDX_LSB = WORD_OFF_BITS + 2;
   localparam int TAG_LSB = INDEX_BITS + WORD_OFF_BITS + 2;
   localparam int TAG_W   = ADDR_TYPE - TAG_LSB;
   localparam int SETS    = 1 << INDEX_BITS;
   localparam int WORDS   = 1 << WORD_OFF_BITS;

   logic [SETS-1:0]          valid;
   logic [TAG_W-1:0]         tags [SETS];
   inst_t                    data [SETS*WORDS];

   logic [INDEX_BITS-1:0]    rd_idx;
   logic [WORD_OFF_BITS-1:0] rd_off;
   logic [TAG_W-1:0]         rd_tag;
   logic [INDEX_BITS-1:0]    wr_idx;
   logic [TAG_W-1:0]         wr_tag;

   assign rd_idx = rd_addr[TAG_LSB-1:IDX_LSB];
   assign rd_off = rd_addr[IDX_LSB-1:2];
   assign rd_tag = rd_addr[ADDR_TYPE-1:TAG_LSB];
   assign wr_idx = line_addr[TAG_LSB-1:IDX_LSB];
   assign wr_tag = line_addr[ADDR_TYPE-1:TAG_LSB];

   assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
   assign rd_word = data[{rd_idx, rd_off}];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (en) begin
         if (clr_valid) begin
            valid[wr_idx] <= FALSE;
         end
         if (set_valid) begin
            valid[wr_idx] <= TRUE;
            tags[wr_idx]  <= wr_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && en && wr_en) begin
         data[{wr_idx, wr_off}] <= wr_word;
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC, direct-mapped I-cache lookup and line refill FSM.
// Ports: clk/rst/rdy, memory refill handshake (mem_*), stall/redirect in, inst_valid/inst/inst_pc out.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int    INDEX_BITS    = DEF_INDEX_BITS,
   parameter int    WORD_OFF_BITS = DEF_WORD_OFF_BITS,
   parameter addr_t RESET_PC      = ADDR_RESET
) (
   input  logic  clk_in,
   input  logic  rst_in,
   input  logic  rdy_in,
   output logic  mem_enable_out,
   output addr_t mem_addr_out,
   input  logic  mem_available_in,
   input  logic  mem_word_valid_in,
   input  inst_t mem_word_in,
   input  logic  mem_end_in,
   input  logic  stall_in,
   input  logic  redirect_in,
   input  addr_t redirect_pc_in,
   output logic  inst_valid_out,
   output inst_t inst_out,
   output addr_t inst_pc_out
);

   localparam int WORDS    = 1 << WORD_OFF_BITS;
   localparam int LINE_LSB = WORD_OFF_BITS + 2;

   localparam logic [WORD_OFF_BITS:0] CNT_FULL = (WORD_OFF_BITS+1)'(WORDS);
   localparam logic [WORD_OFF_BITS:0] CNT_ONE  = (WORD_OFF_BITS+1)'(1);
   localparam logic [WORD_OFF_BITS:0] CNT_LAST = CNT_FULL - CNT_ONE;

   fetch_state_t             state;
   addr_t                    pc;
   logic [WORD_OFF_BITS:0]   cnt;
   logic                     redirect_pending;

   logic                     hit;
   inst_t                    hit_word;
   logic                     word_wr;
   logic                     line_done;
   logic                     line_full;
   logic                     clr_valid;

   // Words past a full line are ignored so a chatty controller cannot wrap the counter.
   assign word_wr   = (state == REFILL) && mem_word_valid_in && (cnt != CNT_FULL);
   assign line_done = word_wr && (cnt == CNT_LAST);
   assign line_full = (cnt == CNT_FULL) || line_done;
   // The old line is invalidated as the refill starts so partial data never hits.
   assign clr_valid = (state == REQ) && mem_available_in && !redirect_in;

   icache_array #(
      .INDEX_BITS    (INDEX_BITS),
      .WORD_OFF_BITS (WORD_OFF_BITS)
   ) u_icache (
      .clk       (clk_in),
      .rst       (rst_in),
      .en        (rdy_in),
      .rd_addr   (pc[ADDR_TYPE-1:2]),
      .hit       (hit),
      .rd_word   (hit_word),
      .wr_en     (word_wr),
      .line_addr (mem_addr_out[ADDR_TYPE-1:LINE_LSB]),
      .wr_off    (cnt[WORD_OFF_BITS-1:0]),
      .wr_word   (mem_word_in),
      .set_valid (line_done),
      .clr_valid (clr_valid)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state            <= LOOKUP;
         pc               <= RESET_PC;
         cnt              <= '0;
         redirect_pending <= FALSE;
         mem_enable_out   <= FALSE;
         mem_addr_out     <= ADDR_RESET;
         inst_valid_out   <= FALSE;
         inst_out         <= INST_RESET;
         inst_pc_out      <= ADDR_RESET;
      end else if (rdy_in) begin
         inst_valid_out <= FALSE;
         unique case (state)
            LOOKUP: begin
               if (redirect_in) begin
                  pc               <= redirect_pc_in;
                  redirect_pending <= FALSE;
               end else begin
                  redirect_pending <= FALSE;
                  if (!hit) begin
                     state          <= REQ;
                     mem_enable_out <= TRUE;
                     mem_addr_out   <= line_base(pc, WORD_OFF_BITS);
                  end else if (!stall_in && !redirect_pending) begin
                     inst_valid_out <= TRUE;
                     inst_out       <= hit_word;
                     inst_pc_out    <= pc;
                     pc             <= pc + 32'd4;
                  end
               end
            end
            REQ: begin
               if (redirect_in) begin
                  pc               <= redirect_pc_in;
                  redirect_pending <= FALSE;
                  mem_enable_out   <= FALSE;
                  state            <= LOOKUP;
               end else if (mem_available_in) begin
                  cnt   <= '0;
                  state <= REFILL;
               end
            end
            REFILL: begin
               // The fill continues to the old line; only the PC follows the redirect.
               if (redirect_in) begin
                  pc               <= redirect_pc_in;
                  redirect_pending <= TRUE;
               end
               if (word_wr) begin
                  cnt <= cnt + CNT_ONE;
               end
               if (mem_end_in) begin
                  if (line_full) begin
                     mem_enable_out <= FALSE;
                     state          <= DRAIN;
                  end else begin
                     state <= REQ;
                  end
               end
            end
            DRAIN: begin
               if (redirect_in) begin
                  pc               <= redirect_pc_in;
                  redirect_pending <= TRUE;
               end
               if (mem_available_in) begin
                  state <= LOOKUP;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard testbench for inst_fetch_unit with a simple line-refill memory model.
// Directed redirect/stall/reset sequence; expected instructions and requests are queued.
module tb_inst_fetch_unit;
   import inst_fetch_unit_pkg::*;

   logic  clk_in = 1'b0;
   logic  rst_in;
   logic  rdy_in;
   logic  mem_enable_out;
   addr_t mem_addr_out;
   logic  mem_available_in;
   logic  mem_word_valid_in;
   inst_t mem_word_in;
   logic  mem_end_in;
   logic  stall_in;
   logic  redirect_in;
   addr_t redirect_pc_in;
   logic  inst_valid_out;
   inst_t inst_out;
   addr_t inst_pc_out;

   always #5 clk_in = ~clk_in;

   inst_fetch_unit dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .rdy_in            (rdy_in),
      .mem_enable_out    (mem_enable_out),
      .mem_addr_out      (mem_addr_out),
      .mem_available_in  (mem_available_in),
      .mem_word_valid_in (mem_word_valid_in),
      .mem_word_in       (mem_word_in),
      .mem_end_in        (mem_end_in),
      .stall_in          (stall_in),
      .redirect_in       (redirect_in),
      .redirect_pc_in    (redirect_pc_in),
      .inst_valid_out    (inst_valid_out),
      .inst_out          (inst_out),
      .inst_pc_out       (inst_pc_out)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] req_q [$];
   exp_t        e_m;
   logic [31:0] r_m;
   int          passed = 0;
   int          total = 0;
   int          rcv = 0;
   int          words_done = 0;
   logic        prev_en = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0000_0013;
         32'h4:   return 32'h0010_0093;
         32'h8:   return 32'h0020_0113;
         32'hC:   return 32'h0030_0193;
         default: return 32'hC0DE_0000 | {16'h0, a[15:0]};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %h, required %h", name, act, expv);
   endtask

   task automatic push_inst(input logic [31:0] pc);
      exp_q.push_back('{pc: pc, inst: mem_word(pc)});
   endtask

   // Monitor: compares every emitted instruction and every new refill request.
   always @(negedge clk_in) begin
      if (inst_valid_out) begin
         rcv++;
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_inst: got pc %h inst %h, required none",
                     inst_pc_out, inst_out);
         end else begin
            e_m = exp_q.pop_front();
            check("inst_pc", inst_pc_out, e_m.pc);
            check("inst_word", inst_out, e_m.inst);
         end
      end
      if (mem_enable_out && !prev_en) begin
         if (req_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_req: got addr %h, required none",
                     mem_addr_out);
         end else begin
            r_m = req_q.pop_front();
            check("req_addr", mem_addr_out, r_m);
         end
      end
      prev_en = mem_enable_out;
   end

   // Memory model: accept, then four spaced word pulses, then an end pulse.
   initial begin
      logic [31:0] base;
      mem_available_in  = 1'b1;
      mem_word_valid_in = 1'b0;
      mem_word_in       = '0;
      mem_end_in        = 1'b0;
      forever begin
         @(negedge clk_in);
         if (mem_enable_out && mem_available_in) begin
            base = mem_addr_out;
            @(posedge clk_in); #1 mem_available_in = 1'b0;
            for (int i = 0; i < 4; i++) begin
               @(posedge clk_in); #1;
               mem_word_valid_in = 1'b1;
               mem_word_in = mem_word(base + 32'(4 * i));
               @(posedge clk_in); #1;
               mem_word_valid_in = 1'b0;
               words_done++;
            end
            @(posedge clk_in); #1 mem_end_in = 1'b1;
            @(posedge clk_in); #1;
            mem_end_in = 1'b0;
            mem_available_in = 1'b1;
         end
      end
   end

   task automatic wait_count(input int n);
      int c;
      c = 0;
      while (rcv < n && c < 2000) begin
         @(negedge clk_in); #1;
         c++;
      end
      if (rcv < n) begin
         total++;
         $display("FAIL wait_count: got %0d outputs, required %0d", rcv, n);
      end
   endtask

   task automatic wait_words(input int n);
      int c;
      c = 0;
      while (words_done < n && c < 2000) begin
         @(negedge clk_in); #1;
         c++;
      end
      if (words_done < n) begin
         total++;
         $display("FAIL wait_words: got %0d words, required %0d", words_done, n);
      end
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_pc_in = target;
      redirect_in = 1'b1;
      @(posedge clk_in); #1 redirect_in = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int hold;
      rst_in = 1'b1;
      rdy_in = 1'b1;
      stall_in = 1'b0;
      redirect_in = 1'b0;
      redirect_pc_in = '0;
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_valid", 32'(inst_valid_out), 32'd0);
      check("rst_enable", 32'(mem_enable_out), 32'd0);
      check("rst_addr", mem_addr_out, 32'h0);
      check("rst_inst", inst_out, 32'h0);
      check("rst_pc", inst_pc_out, 32'h0);

      // Cold miss at PC 0.
      req_q.push_back(32'h0);
      for (int i = 0; i < 4; i++) push_inst(32'(4 * i));
      rst_in = 1'b0;
      wait_count(4);

      // Warm hit after redirect; no request may appear.
      push_inst(32'h4);
      redirect(32'h4);
      wait_count(5);

      // Three stalled cycles mid-line.
      stall_in = 1'b1;
      hold = rcv;
      repeat (3) @(negedge clk_in);
      #1;
      check("stall_hold", 32'(rcv), 32'(hold));
      stall_in = 1'b0;
      push_inst(32'h8);
      push_inst(32'hC);
      wait_count(7);

      // Redirect during refill of 0x110.
      req_q.push_back(32'h110);
      base = words_done;
      redirect(32'h110);
      wait_words(base + 2);
      push_inst(32'h8);
      push_inst(32'hC);
      redirect(32'h8);
      wait_count(9);

      // Line 0x110 must have completed: all four hit without a request.
      for (int i = 0; i < 4; i++) push_inst(32'h110 + 32'(4 * i));
      redirect(32'h110);
      wait_count(13);

      // Index conflict: 0x100 evicts line 0, so 0x0 misses again.
      req_q.push_back(32'h100);
      push_inst(32'h100);
      redirect(32'h100);
      wait_count(14);
      req_q.push_back(32'h0);
      push_inst(32'h0);
      redirect(32'h0);
      wait_count(15);

      // Reset in the middle of a refill.
      req_q.push_back(32'h200);
      base = words_done;
      redirect(32'h200);
      wait_words(base + 2);
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      check("mid_rst_enable", 32'(mem_enable_out), 32'd0);
      check("mid_rst_valid", 32'(inst_valid_out), 32'd0);
      check("mid_rst_addr", mem_addr_out, 32'h0);
      req_q.push_back(32'h0);
      push_inst(32'h0);
      rst_in = 1'b0;
      wait_count(16);

      // Line 0x110 was valid before reset; it must miss now.
      req_q.push_back(32'h110);
      push_inst(32'h110);
      redirect(32'h110);
      wait_count(17);
      stall_in = 1'b1;

      repeat (20) @(negedge clk_in);
      #1;
      check("inst_queue_left", 32'(exp_q.size()), 32'd0);
      check("req_queue_left", 32'(req_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
